// File: rtl/pipe_stage_pkg.sv
// Shared pipeline definitions: word constants, NOP encodings and the
// occupancy states used by every inter-stage register.
package pipe_stage_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [5:0]  NOP_OPCODE   = 6'h00;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    // Fill bit for the default bubble payload; a bubble decodes as NOP.
    localparam logic        NOP_FILL_BIT = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // Number of payloads held in a given occupancy state.
    function automatic logic [1:0] state_count(input stage_state_e s);
        logic [1:0] n;
        case (s)
            ST_ONE:  n = 2'd1;
            ST_TWO:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Payload holding register: loads on enable, holds otherwise, and clears
// asynchronously to the bubble value so no X ever reaches the datapath.
module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Enable register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLEAR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register between two processor stages.
// SKID=1: two-entry skid stage, in_ready depends only on held state plus
//         stall/flush, so out_ready never reaches in_ready combinationally.
// SKID=0: single-entry stage; a full stage accepts only when it drains in
//         the same cycle.
// stall blocks acceptance but not draining, so a stalled stage empties and
// presents a bubble. flush squashes everything, including the in-cycle input.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, out_data shows NOP_DATA
//   ST_ONE   | main register holds the head payload
//   ST_TWO   | main holds head, skid holds next (SKID=1 only)
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      SKID     = 1,
    parameter logic [WIDTH-1:0] NOP_DATA = {WIDTH{NOP_FILL_BIT}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       count
);

    stage_state_e     state_q;
    stage_state_e     state_d;
    logic             accept;
    logic             pop;
    logic             room;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             skid_en;
    logic [WIDTH-1:0] skid_q;

    // Acceptance: room comes from registered state only when SKID is set;
    // reset also forces in_ready low.
    always_comb begin
        room = 1'b0;
        if (SKID != 0) begin
            room = (state_q != ST_TWO);
        end else begin
            room = (state_q == ST_EMPTY) || out_ready;
        end
        in_ready = room && !stall && !flush && rst_n;
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != ST_EMPTY);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? main_q : NOP_DATA;
    assign count     = state_count(state_q);

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and payload-register load control; flush wins over all.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_en = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_en = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        state_d = ST_TWO;
                        skid_en = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .CLEAR_VAL (NOP_DATA)
    ) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    // With SKID=0 the skid enable is never raised, so this register is
    // constant and removed by synthesis.
    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .CLEAR_VAL (NOP_DATA)
    ) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: a queue-based scoreboard tracks the SKID=1 stage
// every cycle; directed scenarios cover streaming, backpressure, stall
// bubble, flush priority, mid-transfer reset and the SKID=0 variant.
module tb_pipe_stage;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         stall;
    logic         flush;
    logic [1:0]   count;

    logic         iv0;
    logic [W-1:0] id0;
    logic         ir0;
    logic         ov0;
    logic [W-1:0] od0;
    logic         or0;
    logic         st0;
    logic         fl0;
    logic [1:0]   c0;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] sb_q[$];

    pipe_stage #(.WIDTH(W), .SKID(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall     (stall),
        .flush     (flush),
        .count     (count)
    );

    pipe_stage #(.WIDTH(W), .SKID(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv0),
        .in_data   (id0),
        .in_ready  (ir0),
        .out_valid (ov0),
        .out_data  (od0),
        .out_ready (or0),
        .stall     (st0),
        .flush     (fl0),
        .count     (c0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard update on each edge: push on acceptance, pop on drain.
    always @(posedge clk) begin
        logic acc;
        logic pp;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            acc = in_valid && (sb_q.size() < 2) && !stall && !flush;
            pp  = (sb_q.size() != 0) && out_ready;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (pp) void'(sb_q.pop_front());
                if (acc) sb_q.push_back(in_data);
            end
        end
    end

    always @(negedge rst_n) sb_q.delete();

    // Compare the SKID=1 stage against the scoreboard away from the edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_data;
        if (rst_n) begin
            exp_data = (sb_q.size() != 0) ? sb_q[0] : '0;
            check_eq("mon_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            check_eq("mon_count",     64'(count),     64'(sb_q.size()));
            check_eq("mon_out_data",  64'(out_data),  64'(exp_data));
            check_eq("mon_in_ready",  64'(in_ready),
                     64'((sb_q.size() < 2) && !stall && !flush));
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        iv0 = 1'b0; id0 = '0; or0 = 1'b0; st0 = 1'b0; fl0 = 1'b0;
        #2;
        in_valid = 1'b1;
        iv0 = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_count",     64'(count),     64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd0);
        check_eq("rst_in_ready0", 64'(ir0),       64'd0);
        in_valid = 1'b0;
        iv0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Streaming through an empty stage.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h11; step();
        check_eq("stream_11", 64'(out_data), 64'h11);
        check_eq("stream_cnt1", 64'(count), 64'd1);
        in_data = 32'h22; step();
        check_eq("stream_22", 64'(out_data), 64'h22);
        check_eq("stream_cnt2", 64'(count), 64'd1);
        in_data = 32'h33; step();
        check_eq("stream_33", 64'(out_data), 64'h33);
        check_eq("stream_cnt3", 64'(count), 64'd1);
        in_valid = 1'b0; step();
        check_eq("stream_empty", 64'(out_valid), 64'd0);

        // Backpressure fills the skid entry.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; step();
        in_data = 32'hA2; step();
        in_valid = 1'b0;
        #1;
        check_eq("bp_count", 64'(count), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_head", 64'(out_data), 64'hA1);
        out_ready = 1'b1; step();
        check_eq("bp_second", 64'(out_data), 64'hA2);
        check_eq("bp_cnt_after", 64'(count), 64'd1);
        step();
        check_eq("bp_drained", 64'(count), 64'd0);

        // Stall drains to a bubble and refuses new data.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77; step();
        stall = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        #1;
        check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        step();
        check_eq("stall_bubble_v", 64'(out_valid), 64'd0);
        check_eq("stall_bubble_d", 64'(out_data), 64'd0);
        stall = 1'b0; in_valid = 1'b0; step();
        check_eq("stall_not_taken", 64'(count), 64'd0);

        // Flush beats accept and pop in the same cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hB1; step();
        in_data = 32'hB2; step();
        check_eq("flush_pre_cnt", 64'(count), 64'd2);
        flush = 1'b1; in_data = 32'hC1; out_ready = 1'b1; step();
        check_eq("flush_cnt", 64'(count), 64'd0);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; step();
        check_eq("flush_no_c1", 64'(out_valid), 64'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        check_eq("rand_drained", 64'(count), 64'd0);

        // Reset in the middle of a full stage.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hD1; step();
        in_data = 32'hD2; step();
        in_valid = 1'b0;
        check_eq("mrst_pre_cnt", 64'(count), 64'd2);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_count", 64'(count), 64'd0);
        check_eq("mrst_data",  64'(out_data), 64'd0);
        check_eq("mrst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'hE1; step();
        check_eq("mrst_first_acc", 64'(out_data), 64'hE1);
        in_valid = 1'b0; out_ready = 1'b1; step();

        // SKID=0 variant.
        iv0 = 1'b1; id0 = 32'h10; or0 = 1'b0; step();
        check_eq("s0_cnt1", 64'(c0), 64'd1);
        check_eq("s0_data1", 64'(od0), 64'h10);
        check_eq("s0_in_ready_full", 64'(ir0), 64'd0);
        id0 = 32'h20; or0 = 1'b1;
        #1;
        check_eq("s0_in_ready_pass", 64'(ir0), 64'd1);
        step();
        check_eq("s0_pass_data", 64'(od0), 64'h20);
        check_eq("s0_pass_cnt", 64'(c0), 64'd1);
        iv0 = 1'b0; step();
        check_eq("s0_empty_v", 64'(ov0), 64'd0);
        check_eq("s0_empty_d", 64'(od0), 64'd0);
        check_eq("s0_empty_c", 64'(c0), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
